mem_stage_ctrl: RTL

- Consumer end of the EX/MEM pipeline boundary. Takes the registered EX/MEM fields and runs the data-memory access with a req/ready handshake.
- Stalls upstream stages while a memory access is outstanding.
- Registers the writeback packet for the MEM/WB boundary (write-enable, destination register, data).
- Detects misaligned addresses and memory timeouts and reports them on a sticky error flag.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 42 ++++
 rtl/mem_stage_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM stage control logic.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Register 31 reads as zero and is never written.
  localparam logic [4:0] XZR = 5'd31;

  // Data-memory accesses must be aligned to 2**ALIGN_BITS bytes.
  localparam int ALIGN_BITS = 3;

  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that measures how long a memory access has been waiting.
// Latency: the count updates one cycle after clr_i/en_i; term_o is decoded from the registered count.
// Backpressure: none; the count saturates at TIMEOUT and never wraps.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over enable; hold once the saturation value is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the last cycle of waiting before the access is abandoned.
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs data-memory accesses for EX/MEM and registers the MEM/WB packet.
// Latency: non-memory ops and misaligned accesses 1 cycle; memory ops 1 cycle plus the ACCESS cycles up to dmem_ready.
// Backpressure: stall holds upstream from the accept cycle until the completion (or timeout) cycle of an access.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [4:0]        Rd,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] Db,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_Rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              mem_err_q, mem_err_d;

  logic is_mem, mis, timeout, stall_c;
  logic ctr_clr, ctr_en, ctr_term;

  assign is_mem  = MemWrite | MemToReg;
  assign mis     = is_misaligned(ALUResult[ALIGN_BITS-1:0]);
  assign timeout = (state_q == ACCESS) & ctr_term & ~dmem_ready;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ctr_clr),
    .en_i   (ctr_en),
    .term_o (ctr_term)
  );

  // Next-state, latch and writeback-packet selection for the IDLE/ACCESS FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    wb_valid_d    = wb_valid_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    mem_err_d     = mem_err_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    stall_c       = 1'b0;

    case (state_q)
      IDLE: begin
        wb_valid_d = 1'b0;
        if (in_valid) begin
          if (!is_mem) begin
            // Plain ALU result goes straight to writeback.
            wb_valid_d    = 1'b1;
            wb_regwrite_d = RegWrite & (Rd != XZR);
            wb_rd_d       = Rd;
            wb_data_d     = DATA_W'(ALUResult);
          end else if (mis) begin
            // Misaligned access is dropped without touching memory.
            mem_err_d     = 1'b1;
            wb_valid_d    = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_rd_d       = Rd;
          end else begin
            // Capture the request; upstream must hold until completion.
            stall_c    = 1'b1;
            addr_d     = ALUResult;
            wdata_d    = Db;
            we_d       = MemWrite;
            rd_d       = Rd;
            regwrite_d = RegWrite;
            memtoreg_d = MemToReg;
            ctr_clr    = 1'b1;
            state_d    = ACCESS;
          end
        end
      end

      ACCESS: begin
        ctr_en = ~dmem_ready;
        if (dmem_ready) begin
          // Completion: a store never writes the register file.
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_data_d     = memtoreg_q ? dmem_rdata : DATA_W'(addr_q);
          wb_regwrite_d = regwrite_q & memtoreg_q & (rd_q != XZR);
        end else if (timeout) begin
          // Abandon the access and report it.
          state_d       = IDLE;
          mem_err_d     = 1'b1;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_rd_d       = rd_q;
        end else begin
          stall_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latches and writeback packet registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      mem_err_q     <= mem_err_d;
    end
  end

  // Nothing is held upstream while reset is asserted, even if in_valid is still high.
  assign stall       = reset & stall_c;
  assign dmem_req    = (state_q == ACCESS);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_Rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_err     = mem_err_q;

endmodule
